trace_write_arbiter: RTL and testbench
======================================

// Module: trace_write_arbiter
// PURPOSE
//  Shares the single write port of trace_buffer between NUM_SOURCES trace producers.
//  Each source has a one-entry holding register and a valid/ready handshake.
//  A round-robin arbiter forwards at most one element per clock as a registered write strobe (buf_wr_valid -> ready_signal).
//  A small FSM provides enable/idle and a flush sequence that drains pending entries before reporting done.
// PARAMETERS
//  NUM_SOURCES  4   number of trace producers, >=2
//  DATA_WIDTH   64  width of one trace element, bits
//  SRC_W        $clog2(NUM_SOURCES)  derived; width of source id
// PORTS
//  clk            in   1                       clock, all state on posedge
//  rst_n          in   1                       asynchronous active-low reset
//  enable         in   1                       1 = accept and forward trace elements
//  flush_req      in   1                       1-cycle pulse: stop accepting, drain holding regs
//  src_valid      in   NUM_SOURCES             per-source element valid
//  src_data       in   NUM_SOURCES*DATA_WIDTH  per-source element, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//  src_ready      out  NUM_SOURCES             per-source ready (combinational)
//  buf_wr_valid   out  1                       one-cycle write strobe to trace_buffer ready_signal
//  buf_wr_data    out  DATA_WIDTH              element to trace_buffer trace_element_in
//  buf_wr_src     out  SRC_W                   id of source that produced buf_wr_data
//  flush_done     out  1                       one-cycle pulse when flush completes
//  busy           out  1                       1 while any holding register is occupied
//  wr_count       out  32                      number of elements written, saturates at 2^32-1
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE; all pend_valid=0; rr_ptr=0; buf_wr_valid=0; buf_wr_data=0; buf_wr_src=0; flush_done=0; wr_count=0.
//  FSM states: IDLE, RUN, DRAIN.
//   IDLE:  src_ready=0, no grants; enable=1 -> RUN; flush_req -> DRAIN.
//   RUN:   accept and grant; flush_req -> DRAIN (flush_req wins over enable=0); enable=0 -> IDLE, pending entries retained.
//   DRAIN: src_ready=0; grants continue. When no pend_valid remains and no grant is issued this cycle: pulse flush_done, go to IDLE.
//   flush_req in DRAIN: ignored.
//  Handshake:
//   src_ready[i] = (state==RUN) && (!pend_valid[i] || grant[i]).
//   Transfer occurs on a posedge with src_valid[i]&&src_ready[i]: pend_data[i]<=src_data[i], pend_valid[i]<=1.
//   src_data is stable while src_valid=1 && src_ready=0 (source obligation).
//  Arbitration (combinational, RUN or DRAIN):
//   Grant the first i with pend_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_SOURCES. At most one grant per cycle.
//   On a grant to i, posedge: buf_wr_valid<=1, buf_wr_data<=pend_data[i], buf_wr_src<=i, rr_ptr<=(i+1)%NUM_SOURCES.
//   On that same edge pend_valid[i] clears unless a new transfer into i occurs, which reloads the register: back-to-back, no bubble.
//   With no grant, buf_wr_valid<=0; buf_wr_data/buf_wr_src hold.
//  Latency: element accepted at edge k appears on buf_wr_valid after edge k+1 at the earliest.
//   Worst case is NUM_SOURCES cycles with all sources pending.
//  Throughput: 1 element/clock aggregate; each source is guaranteed a slot within NUM_SOURCES cycles.
//  Outputs are registered on posedge, so they are stable at the negedge where trace_buffer samples.
//  wr_count increments on every cycle buf_wr_valid=1; it holds at 32'hFFFF_FFFF.
//  busy = |pend_valid (combinational).
//  rr_ptr wraps NUM_SOURCES-1 -> 0.
//  Reset mid-operation discards pending and in-flight elements; no partial write is issued after rst_n deasserts.
// TESTING
//  1. Reset, enable=1, src0 valid data=0xA5 one cycle -> buf_wr_valid 1 cycle later, data=0xA5, src=0, wr_count=1.
//  2. All 4 sources valid every cycle for 8 cycles, rr_ptr=0 -> buf_wr_src sequence 0,1,2,3,0,1,2,3; buf_wr_valid continuous; no data lost.
//  3. src2 held valid 4 cycles with data 1,2,3,4, others idle -> writes 1,2,3,4 on consecutive cycles, src_ready[2] stays 1.
//  4. Load src1 and src3, drop enable -> IDLE, busy=1, no writes. Pulse flush_req -> two writes (src1, then src3), flush_done pulse next cycle, busy=0.
//  5. Force wr_count to 0xFFFF_FFFF, perform a write -> wr_count stays 0xFFFF_FFFF.
//  6. Assert rst_n=0 asynchronously mid-stream with 3 pending -> outputs zero immediately; after release, no buf_wr_valid until new input is accepted.

Source files
------------

// File: rtl/trace_write_arbiter_if.sv
// Handshake and write-port bundle between the trace producers, the arbiter and trace_buffer.
interface trace_write_arbiter_if #(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_WIDTH  = 64
);
    localparam int SRC_W = $clog2(NUM_SOURCES);

    logic                              enable;
    logic                              flush_req;
    logic [NUM_SOURCES-1:0]            src_valid;
    logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data;
    logic [NUM_SOURCES-1:0]            src_ready;
    logic                              buf_wr_valid;
    logic [DATA_WIDTH-1:0]             buf_wr_data;
    logic [SRC_W-1:0]                  buf_wr_src;
    logic                              flush_done;
    logic                              busy;
    logic [31:0]                       wr_count;

    modport master (
        output enable, flush_req, src_valid, src_data,
        input  src_ready, buf_wr_valid, buf_wr_data, buf_wr_src, flush_done, busy, wr_count
    );

    modport slave (
        input  enable, flush_req, src_valid, src_data,
        output src_ready, buf_wr_valid, buf_wr_data, buf_wr_src, flush_done, busy, wr_count
    );
endinterface

// File: rtl/trace_write_arbiter.sv
// Round-robin arbiter sharing the trace_buffer write port between NUM_SOURCES producers,
// each with a one-entry holding register, plus an enable/idle/flush control FSM.
module trace_write_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_WIDTH  = 64
) (
    input  logic clk,
    input  logic rst_n,
    trace_write_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_SOURCES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_SOURCES-1:0] pend_valid;
    logic [DATA_WIDTH-1:0]  pend_data [NUM_SOURCES];
    logic [SRC_W-1:0]       rr_ptr;
    logic [NUM_SOURCES-1:0] grant;
    logic                   grant_any;
    logic [SRC_W-1:0]       grant_id;
    logic [NUM_SOURCES-1:0] src_ready;
    logic [NUM_SOURCES-1:0] load;
    logic                   drain_done;
    logic                   wr_valid;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [SRC_W-1:0]       wr_src;
    logic                   flush_done;
    logic [31:0]            wr_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] i);
        return (i == SRC_W'(NUM_SOURCES - 1)) ? '0 : i + 1'b1;
    endfunction

    // Search starts at rr_ptr so the last-served source drops to lowest priority.
    always_comb begin
        int               idx_i;
        logic [SRC_W-1:0] idx;
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        idx_i     = 0;
        idx       = '0;
        if (state != IDLE) begin
            for (int k = 0; k < NUM_SOURCES; k++) begin
                idx_i = (int'(rr_ptr) + k) % NUM_SOURCES;
                idx   = SRC_W'(idx_i);
                if (!grant_any && pend_valid[idx]) begin
                    grant[idx] = 1'b1;
                    grant_any  = 1'b1;
                    grant_id   = idx;
                end
            end
        end
    end

    // A granted register empties this edge, so it can reload without a bubble.
    assign src_ready  = (state == RUN) ? (~pend_valid | grant) : '0;
    assign load       = bus.src_valid & src_ready;
    assign drain_done = (state == DRAIN) && (pend_valid == '0) && !grant_any;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.flush_req)   state_nxt = DRAIN;
                else if (bus.enable) state_nxt = RUN;
            end
            RUN: begin
                if (bus.flush_req)    state_nxt = DRAIN;
                else if (!bus.enable) state_nxt = IDLE;
            end
            DRAIN: begin
                if (drain_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend_valid <= '0;
            rr_ptr     <= '0;
            wr_valid   <= 1'b0;
            wr_data    <= '0;
            wr_src     <= '0;
            flush_done <= 1'b0;
            wr_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            pend_valid <= (pend_valid & ~grant) | load;
            wr_valid   <= grant_any;
            flush_done <= drain_done;
            if (grant_any) begin
                wr_data <= pend_data[grant_id];
                wr_src  <= grant_id;
                rr_ptr  <= next_ptr(grant_id);
            end
            if (wr_valid) wr_cnt <= sat_inc(wr_cnt);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (load[i]) pend_data[i] <= bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.src_ready    = src_ready;
    assign bus.buf_wr_valid = wr_valid;
    assign bus.buf_wr_data  = wr_data;
    assign bus.buf_wr_src   = wr_src;
    assign bus.flush_done   = flush_done;
    assign bus.busy         = |pend_valid;
    assign bus.wr_count     = wr_cnt;
endmodule

// File: tb/tb_trace_write_arbiter.sv
// Directed bench for trace_write_arbiter: vector table for arbitration/handshake, hand sequences for flush, saturation and reset.
module tb_trace_write_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    trace_write_arbiter_if #(.NUM_SOURCES(4), .DATA_WIDTH(64)) bus ();

    trace_write_arbiter #(.NUM_SOURCES(4), .DATA_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  ready;
        logic        wv;
        logic [1:0]  wsrc;
        logic [63:0] wdata;
    } vec_t;

    vec_t        vecs [19];
    logic [63:0] base [4];
    int unsigned seq  [4];
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] r, input logic wv,
                                input logic [1:0] ws, input logic [63:0] wd);
        vec_t t;
        t.valid = v; t.ready = r; t.wv = wv; t.wsrc = ws; t.wdata = wd;
        return t;
    endfunction

    task automatic drive_src();
        for (int i = 0; i < 4; i++) bus.src_data[i*64 +: 64] = base[i] + 64'(seq[i]);
    endtask

    task automatic run_rows(input int first, input int last);
        logic [3:0] hs;
        for (int r = first; r <= last; r++) begin
            bus.src_valid = vecs[r].valid;
            drive_src();
            #1;
            chk($sformatf("row%0d src_ready", r), 64'(bus.src_ready), 64'(vecs[r].ready));
            hs = bus.src_valid & bus.src_ready;
            tick();
            for (int i = 0; i < 4; i++) if (hs[i]) seq[i]++;
            chk($sformatf("row%0d buf_wr_valid", r), 64'(bus.buf_wr_valid), 64'(vecs[r].wv));
            if (vecs[r].wv) begin
                chk($sformatf("row%0d buf_wr_src", r), 64'(bus.buf_wr_src), 64'(vecs[r].wsrc));
                chk($sformatf("row%0d buf_wr_data", r), bus.buf_wr_data, vecs[r].wdata);
            end
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.enable    = 1'b0;
        bus.flush_req = 1'b0;
        bus.src_valid = '0;
        bus.src_data  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1);
    end

    initial begin
        // test 2: all sources streaming, stalled sources keep their data stable
        vecs[0]  = mk(4'hF, 4'hF, 1'b0, 2'd0, 64'h0);
        vecs[1]  = mk(4'hF, 4'h1, 1'b1, 2'd0, 64'h000);
        vecs[2]  = mk(4'hF, 4'h2, 1'b1, 2'd1, 64'h100);
        vecs[3]  = mk(4'hF, 4'h4, 1'b1, 2'd2, 64'h200);
        vecs[4]  = mk(4'hF, 4'h8, 1'b1, 2'd3, 64'h300);
        vecs[5]  = mk(4'hF, 4'h1, 1'b1, 2'd0, 64'h001);
        vecs[6]  = mk(4'hF, 4'h2, 1'b1, 2'd1, 64'h101);
        vecs[7]  = mk(4'hF, 4'h4, 1'b1, 2'd2, 64'h201);
        vecs[8]  = mk(4'h0, 4'h8, 1'b1, 2'd3, 64'h301);
        vecs[9]  = mk(4'h0, 4'h9, 1'b1, 2'd0, 64'h002);
        vecs[10] = mk(4'h0, 4'hB, 1'b1, 2'd1, 64'h102);
        vecs[11] = mk(4'h0, 4'hF, 1'b1, 2'd2, 64'h202);
        vecs[12] = mk(4'h0, 4'hF, 1'b0, 2'd0, 64'h0);
        // test 3: src2 alone, data 1..4 back to back
        vecs[13] = mk(4'h4, 4'hF, 1'b0, 2'd0, 64'h0);
        vecs[14] = mk(4'h4, 4'hF, 1'b1, 2'd2, 64'd1);
        vecs[15] = mk(4'h4, 4'hF, 1'b1, 2'd2, 64'd2);
        vecs[16] = mk(4'h4, 4'hF, 1'b1, 2'd2, 64'd3);
        vecs[17] = mk(4'h0, 4'hF, 1'b1, 2'd2, 64'd4);
        vecs[18] = mk(4'h0, 4'hF, 1'b0, 2'd0, 64'h0);

        do_reset();
        chk("reset buf_wr_valid", 64'(bus.buf_wr_valid), 64'd0);
        chk("reset buf_wr_data", bus.buf_wr_data, 64'd0);
        chk("reset buf_wr_src", 64'(bus.buf_wr_src), 64'd0);
        chk("reset flush_done", 64'(bus.flush_done), 64'd0);
        chk("reset wr_count", 64'(bus.wr_count), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        bus.src_valid = 4'hF;
        #1;
        chk("idle src_ready", 64'(bus.src_ready), 64'd0);
        tick();
        chk("idle no accept busy", 64'(bus.busy), 64'd0);
        bus.src_valid = '0;

        // test 1: single element latency
        bus.enable = 1'b1;
        tick();
        bus.src_valid = 4'b0001;
        bus.src_data  = '0;
        bus.src_data[63:0] = 64'hA5;
        #1;
        chk("t1 src_ready0", 64'(bus.src_ready[0]), 64'd1);
        tick();
        bus.src_valid = '0;
        chk("t1 no early write", 64'(bus.buf_wr_valid), 64'd0);
        chk("t1 busy", 64'(bus.busy), 64'd1);
        tick();
        chk("t1 buf_wr_valid", 64'(bus.buf_wr_valid), 64'd1);
        chk("t1 buf_wr_data", bus.buf_wr_data, 64'hA5);
        chk("t1 buf_wr_src", 64'(bus.buf_wr_src), 64'd0);
        tick();
        chk("t1 strobe one cycle", 64'(bus.buf_wr_valid), 64'd0);
        chk("t1 wr_count", 64'(bus.wr_count), 64'd1);

        // test 2
        do_reset();
        bus.enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin base[i] = 64'(i) << 8; seq[i] = 0; end
        run_rows(0, 12);

        // test 3
        for (int i = 0; i < 4; i++) begin base[i] = 64'h0; seq[i] = 0; end
        base[2] = 64'd1;
        run_rows(13, 18);

        // test 4: load src1/src3, idle, then flush
        do_reset();
        bus.enable = 1'b1;
        tick();
        bus.src_valid = 4'b1010;
        bus.src_data  = '0;
        bus.src_data[1*64 +: 64] = 64'h11;
        bus.src_data[3*64 +: 64] = 64'h33;
        bus.enable = 1'b0;
        tick();
        bus.src_valid = '0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t4 idle no write c%0d", c), 64'(bus.buf_wr_valid), 64'd0);
            chk($sformatf("t4 idle busy c%0d", c), 64'(bus.busy), 64'd1);
            tick();
        end
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        chk("t4 flush start no write", 64'(bus.buf_wr_valid), 64'd0);
        tick();
        chk("t4 w1 valid", 64'(bus.buf_wr_valid), 64'd1);
        chk("t4 w1 src", 64'(bus.buf_wr_src), 64'd1);
        chk("t4 w1 data", bus.buf_wr_data, 64'h11);
        tick();
        chk("t4 w2 valid", 64'(bus.buf_wr_valid), 64'd1);
        chk("t4 w2 src", 64'(bus.buf_wr_src), 64'd3);
        chk("t4 w2 data", bus.buf_wr_data, 64'h33);
        chk("t4 flush_done early", 64'(bus.flush_done), 64'd0);
        tick();
        chk("t4 no third write", 64'(bus.buf_wr_valid), 64'd0);
        chk("t4 flush_done", 64'(bus.flush_done), 64'd1);
        chk("t4 busy clear", 64'(bus.busy), 64'd0);
        chk("t4 wr_count", 64'(bus.wr_count), 64'd2);
        tick();
        chk("t4 flush_done pulse", 64'(bus.flush_done), 64'd0);

        // test 5: wr_count saturation
        force dut.wr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.wr_cnt;
        bus.enable = 1'b1;
        tick();
        bus.src_valid = 4'b0001;
        bus.src_data[63:0] = 64'h55;
        tick();
        bus.src_valid = '0;
        tick();
        chk("t5 write valid", 64'(bus.buf_wr_valid), 64'd1);
        chk("t5 write data", bus.buf_wr_data, 64'h55);
        tick();
        chk("t5 wr_count saturated", 64'(bus.wr_count), 64'hFFFF_FFFF);

        // test 6: async reset mid-stream with three pending
        bus.src_valid = 4'hF;
        bus.src_data  = {64'h44, 64'h33, 64'h22, 64'h11};
        tick();
        bus.src_valid = '0;
        tick();
        chk("t6 in-flight write", 64'(bus.buf_wr_valid), 64'd1);
        chk("t6 pending busy", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 rst buf_wr_valid", 64'(bus.buf_wr_valid), 64'd0);
        chk("t6 rst buf_wr_data", bus.buf_wr_data, 64'd0);
        chk("t6 rst buf_wr_src", 64'(bus.buf_wr_src), 64'd0);
        chk("t6 rst wr_count", 64'(bus.wr_count), 64'd0);
        chk("t6 rst busy", 64'(bus.busy), 64'd0);
        chk("t6 rst src_ready", 64'(bus.src_ready), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("t6 no stale write c%0d", c), 64'(bus.buf_wr_valid), 64'd0);
        end
        bus.src_valid = 4'b0010;
        bus.src_data[1*64 +: 64] = 64'h77;
        tick();
        bus.src_valid = '0;
        tick();
        chk("t6 new write valid", 64'(bus.buf_wr_valid), 64'd1);
        chk("t6 new write src", 64'(bus.buf_wr_src), 64'd1);
        chk("t6 new write data", bus.buf_wr_data, 64'h77);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
